// File: rtl/multicycle_control_if.sv
// Control-unit boundary of the multicycle MIPS datapath: IR fields and status in, selects and strobes out.
interface multicycle_control_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       IorD;
  logic       MemWrite;
  logic       MemRead;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic       illegal;

  modport master (
    input  op, funct, zero, mem_ready,
    output IorD, MemWrite, MemRead, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, illegal
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  IorD, MemWrite, MemRead, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, illegal
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM: one state register, every control output decoded combinationally.
module multicycle_control (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_control_if.master   bus
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPEEX, S_RTYPEWB, S_BEQEX, S_ADDIEX, S_ADDIWB, S_JEX
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  state_t     r_state, w_next;
  logic       w_iord, w_memwrite, w_memread, w_irwrite, w_regdst, w_memtoreg, w_regwrite;
  logic       w_alusrca, w_pcwrite, w_branch, w_illegal;
  logic [1:0] w_alusrcb, w_pcsrc;
  logic [2:0] w_aluctl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_iord     = 1'b0;
    w_memwrite = 1'b0;
    w_memread  = 1'b0;
    w_irwrite  = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'b00;
    w_aluctl   = ALU_ADD;
    w_pcsrc    = 2'b00;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_memread = 1'b1;
        w_alusrcb = 2'b01;
        if (bus.mem_ready) begin
          w_irwrite = 1'b1;
          w_pcwrite = 1'b1;
          w_next    = S_DECODE;
        end
      end
      S_DECODE: begin
        w_alusrcb = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JEX;
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_memread = 1'b1;
        w_iord    = 1'b1;
        if (bus.mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        w_memwrite = 1'b1;
        w_iord     = 1'b1;
        if (bus.mem_ready) w_next = S_FETCH;
      end
      S_RTYPEEX: begin
        w_alusrca = 1'b1;
        case (bus.funct)
          6'b100000: w_aluctl = 3'b010;
          6'b100010: w_aluctl = 3'b110;
          6'b100100: w_aluctl = 3'b000;
          6'b100101: w_aluctl = 3'b001;
          6'b101010: w_aluctl = 3'b111;
          default:   w_illegal = 1'b1;
        endcase
        w_next = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_BEQEX: begin
        w_alusrca = 1'b1;
        w_aluctl  = ALU_SUB;
        w_branch  = 1'b1;
        w_pcsrc   = 2'b01;
        w_next    = S_FETCH;
      end
      S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_JEX: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
        w_next    = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
    // Reset is asynchronous, so strobes are masked combinationally while it is held.
    if (reset) begin
      w_memwrite = 1'b0;
      w_memread  = 1'b0;
      w_irwrite  = 1'b0;
      w_regwrite = 1'b0;
      w_pcwrite  = 1'b0;
      w_branch   = 1'b0;
      w_illegal  = 1'b0;
    end
  end

  assign bus.IorD       = w_iord;
  assign bus.MemWrite   = w_memwrite;
  assign bus.MemRead    = w_memread;
  assign bus.IRWrite    = w_irwrite;
  assign bus.RegDst     = w_regdst;
  assign bus.MemtoReg   = w_memtoreg;
  assign bus.RegWrite   = w_regwrite;
  assign bus.ALUSrcA    = w_alusrca;
  assign bus.ALUSrcB    = w_alusrcb;
  assign bus.ALUControl = w_aluctl;
  assign bus.PCSrc      = w_pcsrc;
  assign bus.PCEn       = w_pcwrite | (w_branch & bus.zero);
  assign bus.illegal    = w_illegal;
endmodule

// File: tb/tb_multicycle_control.sv
// Scenario bench for multicycle_control: per-cycle expected control vectors queued and compared mid-cycle.
module tb_multicycle_control;
  typedef logic [16:0] ov_t;
  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       mr;
    logic       z;
    ov_t        exp;
  } stim_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  multicycle_control_if bus();

  multicycle_control dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  ov_t   outs;
  assign outs = {bus.IorD, bus.MemWrite, bus.MemRead, bus.IRWrite, bus.RegDst, bus.MemtoReg,
                 bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.PCSrc, bus.PCEn,
                 bus.illegal};

  int    n_checks = 0;
  int    n_errors = 0;
  stim_t stim[$];
  ov_t   sb[$];
  ov_t   exp_v, got_v;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

  // Expected output vector: iord mw mr irw rd m2r rw asa asb alu pcs pcen ill
  function automatic ov_t v(logic iord, logic mw, logic mr, logic irw, logic rd, logic m2r,
                            logic rw, logic asa, logic [1:0] asb, logic [2:0] alu,
                            logic [1:0] pcs, logic pcen, logic ill);
    return {iord, mw, mr, irw, rd, m2r, rw, asa, asb, alu, pcs, pcen, ill};
  endfunction

  function automatic ov_t e_rst();          return v(0,0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0,0); endfunction
  function automatic ov_t e_fetch(logic r); return v(0,0,1,r,0,0,0,0,2'b01,3'b010,2'b00,r,0); endfunction
  function automatic ov_t e_dec(logic i);   return v(0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,i); endfunction
  function automatic ov_t e_madr();         return v(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0); endfunction
  function automatic ov_t e_mrd();          return v(1,0,1,0,0,0,0,0,2'b00,3'b010,2'b00,0,0); endfunction
  function automatic ov_t e_mwb();          return v(0,0,0,0,0,1,1,0,2'b00,3'b010,2'b00,0,0); endfunction
  function automatic ov_t e_mwr();          return v(1,1,0,0,0,0,0,0,2'b00,3'b010,2'b00,0,0); endfunction
  function automatic ov_t e_rex(logic [2:0] a, logic i);
    return v(0,0,0,0,0,0,0,1,2'b00,a,2'b00,0,i);
  endfunction
  function automatic ov_t e_rwb();          return v(0,0,0,0,1,0,1,0,2'b00,3'b010,2'b00,0,0); endfunction
  function automatic ov_t e_bex(logic z);   return v(0,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,z,0); endfunction
  function automatic ov_t e_aex();          return v(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0); endfunction
  function automatic ov_t e_awb();          return v(0,0,0,0,0,0,1,0,2'b00,3'b010,2'b00,0,0); endfunction
  function automatic ov_t e_jex();          return v(0,0,0,0,0,0,0,0,2'b00,3'b010,2'b10,1,0); endfunction

  task automatic add(logic [5:0] op, logic [5:0] funct, logic mr, logic z, ov_t exp);
    stim_t s;
    s.op = op; s.funct = funct; s.mr = mr; s.z = z; s.exp = exp;
    stim.push_back(s);
  endtask

  task automatic apply(int i);
    bus.op = stim[i].op; bus.funct = stim[i].funct;
    bus.mem_ready = stim[i].mr; bus.zero = stim[i].z;
    sb.push_back(stim[i].exp);
  endtask

  task automatic test_reset();
    bus.op = OP_R; bus.funct = 6'b100000; bus.mem_ready = 1'b1; bus.zero = 1'b1;
    reset = 1'b1;
    repeat (2) begin
      sb.push_back(e_rst());
      @(negedge clk);
      exp_v = sb.pop_front(); got_v = outs; n_checks++;
      if (got_v !== exp_v) begin
        n_errors++; $display("FAIL reset_hold got %b expected %b", got_v, exp_v);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0; bus.mem_ready = 1'b0;
    sb.push_back(e_fetch(1'b0));
    @(negedge clk);
    exp_v = sb.pop_front(); got_v = outs; n_checks++;
    if (got_v !== exp_v) begin
      n_errors++; $display("FAIL reset_release got %b expected %b", got_v, exp_v);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    add(OP_LW, 0, 1, 0, e_fetch(1)); add(OP_LW, 0, 1, 0, e_dec(0)); add(OP_LW, 0, 1, 0, e_madr());
    add(OP_LW, 0, 1, 0, e_mrd());    add(OP_LW, 0, 0, 0, e_mwb());
    add(OP_LW, 0, 1, 0, e_fetch(1)); add(OP_LW, 0, 0, 0, e_dec(0)); add(OP_LW, 0, 0, 0, e_madr());
    for (int k = 0; k < 3; k++) add(OP_LW, 0, 0, 0, e_mrd());
    add(OP_LW, 0, 1, 0, e_mrd());    add(OP_LW, 0, 1, 0, e_mwb());
    foreach (stim[i]) begin
      apply(i);
      @(negedge clk);
      exp_v = sb.pop_front(); got_v = outs; n_checks++;
      if (got_v !== exp_v) begin
        n_errors++; $display("FAIL lw cyc%0d got %b expected %b", i, got_v, exp_v);
      end
      @(posedge clk); #1;
    end
    stim.delete();
  endtask

  task automatic test_sw();
    add(OP_SW, 0, 0, 0, e_fetch(0)); add(OP_SW, 0, 0, 0, e_fetch(0)); add(OP_SW, 0, 1, 0, e_fetch(1));
    add(OP_SW, 0, 1, 0, e_dec(0));   add(OP_SW, 0, 1, 0, e_madr());
    add(OP_SW, 0, 0, 0, e_mwr());    add(OP_SW, 0, 0, 0, e_mwr());    add(OP_SW, 0, 1, 0, e_mwr());
    add(OP_SW, 0, 0, 0, e_fetch(0));
    foreach (stim[i]) begin
      apply(i);
      @(negedge clk);
      exp_v = sb.pop_front(); got_v = outs; n_checks++;
      if (got_v !== exp_v) begin
        n_errors++; $display("FAIL sw cyc%0d got %b expected %b", i, got_v, exp_v);
      end
      @(posedge clk); #1;
    end
    stim.delete();
  endtask

  task automatic test_beq();
    add(OP_BEQ, 0, 1, 1, e_fetch(1)); add(OP_BEQ, 0, 1, 1, e_dec(0)); add(OP_BEQ, 0, 1, 1, e_bex(1));
    add(OP_BEQ, 0, 1, 1, e_fetch(1)); add(OP_BEQ, 0, 1, 1, e_dec(0)); add(OP_BEQ, 0, 1, 0, e_bex(0));
    add(OP_BEQ, 0, 0, 1, e_fetch(0));
    foreach (stim[i]) begin
      apply(i);
      @(negedge clk);
      exp_v = sb.pop_front(); got_v = outs; n_checks++;
      if (got_v !== exp_v) begin
        n_errors++; $display("FAIL beq cyc%0d got %b expected %b", i, got_v, exp_v);
      end
      @(posedge clk); #1;
    end
    stim.delete();
  endtask

  task automatic test_rtype();
    logic [5:0] fn [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    logic [2:0] ac [6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
    for (int k = 0; k < 6; k++) begin
      add(OP_R, fn[k], 1, 0, e_fetch(1)); add(OP_R, fn[k], 0, 0, e_dec(0));
      add(OP_R, fn[k], 0, 0, e_rex(ac[k], k == 5)); add(OP_R, fn[k], 0, 0, e_rwb());
    end
    foreach (stim[i]) begin
      apply(i);
      @(negedge clk);
      exp_v = sb.pop_front(); got_v = outs; n_checks++;
      if (got_v !== exp_v) begin
        n_errors++; $display("FAIL rtype cyc%0d got %b expected %b", i, got_v, exp_v);
      end
      @(posedge clk); #1;
    end
    stim.delete();
  endtask

  task automatic test_illegal_jump_addi();
    add(6'b111111, 0, 1, 0, e_fetch(1)); add(6'b111111, 0, 1, 0, e_dec(1));
    add(OP_J, 0, 1, 0, e_fetch(1));       add(OP_J, 0, 0, 0, e_dec(0));  add(OP_J, 0, 0, 0, e_jex());
    add(OP_ADDI, 0, 1, 0, e_fetch(1));    add(OP_ADDI, 0, 0, 0, e_dec(0));
    add(OP_ADDI, 0, 1, 0, e_aex());       add(OP_ADDI, 0, 0, 0, e_awb());
    foreach (stim[i]) begin
      apply(i);
      @(negedge clk);
      exp_v = sb.pop_front(); got_v = outs; n_checks++;
      if (got_v !== exp_v) begin
        n_errors++; $display("FAIL ill_j_addi cyc%0d got %b expected %b", i, got_v, exp_v);
      end
      @(posedge clk); #1;
    end
    stim.delete();
  endtask

  task automatic test_reset_mid_sw();
    add(OP_SW, 0, 1, 0, e_fetch(1)); add(OP_SW, 0, 0, 0, e_dec(0));
    add(OP_SW, 0, 0, 0, e_madr());   add(OP_SW, 0, 0, 0, e_mwr());
    foreach (stim[i]) begin
      apply(i);
      @(negedge clk);
      exp_v = sb.pop_front(); got_v = outs; n_checks++;
      if (got_v !== exp_v) begin
        n_errors++; $display("FAIL rst_mid pre cyc%0d got %b expected %b", i, got_v, exp_v);
      end
      if (i < stim.size() - 1) begin @(posedge clk); #1; end
    end
    stim.delete();
    // Assert reset between edges while MEMWR is still waiting
    #1 reset = 1'b1;
    sb.push_back(e_rst());
    #1;
    exp_v = sb.pop_front(); got_v = outs; n_checks++;
    if (got_v !== exp_v) begin
      n_errors++; $display("FAIL rst_mid async got %b expected %b", got_v, exp_v);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    add(OP_SW, 0, 0, 0, e_fetch(0)); add(OP_SW, 0, 1, 0, e_fetch(1));
    add(OP_ADDI, 0, 0, 0, e_dec(0)); add(OP_ADDI, 0, 0, 0, e_aex()); add(OP_ADDI, 0, 0, 0, e_awb());
    foreach (stim[i]) begin
      apply(i);
      @(negedge clk);
      exp_v = sb.pop_front(); got_v = outs; n_checks++;
      if (got_v !== exp_v) begin
        n_errors++; $display("FAIL rst_mid post cyc%0d got %b expected %b", i, got_v, exp_v);
      end
      @(posedge clk); #1;
    end
    stim.delete();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_beq();
    test_rtype();
    test_illegal_jump_addi();
    test_reset_mid_sw();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
